// File: rtl/demod_conj_mult_pipe.sv
// FM demod front-end: pipelined conjugate product of each sample with its predecessor.
// Define DEMOD_SATURATE_EN to clamp results instead of wrapping them.
module demod_conj_mult_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUANT_BITS  = 10,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   restart,
  output logic                   inA_rd_en,
  input  logic                   inA_empty,
  input  logic [DATA_WIDTH-1:0]  inA_dout,
  output logic                   inB_rd_en,
  input  logic                   inB_empty,
  input  logic [DATA_WIDTH-1:0]  inB_dout,
  output logic                   out_i_wr_en,
  input  logic                   out_i_full,
  output logic [DATA_WIDTH-1:0]  out_i_din,
  output logic                   out_r_wr_en,
  input  logic                   out_r_full,
  output logic [DATA_WIDTH-1:0]  out_r_din,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   busy
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 1;

  localparam logic signed [PW-1:0] BIAS =
    {{(PW-QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};

`ifdef DEMOD_SATURATE_EN
  localparam logic signed [SW-1:0] SMAX =
    {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  typedef struct packed {
    logic                v;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic signed [W-1:0] rp;
    logic signed [W-1:0] ip;
  } p1_t;

  typedef struct packed {
    logic                 v;
    logic signed [PW-1:0] rr;
    logic signed [PW-1:0] ii;
    logic signed [PW-1:0] ri;
    logic signed [PW-1:0] ir;
  } p2_t;

  typedef struct packed {
    logic                v;
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
  } p3_t;

  function automatic logic signed [PW-1:0] mul(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = {{W{a[W-1]}}, a};
    bx = {{W{b[W-1]}}, b};
    return ax * bx;
  endfunction

  // Biasing negatives before the shift makes it round toward zero.
  function automatic logic signed [PW-1:0] dq(
    input logic signed [PW-1:0] x
  );
    logic signed [PW-1:0] b;
    b = x[PW-1] ? BIAS : '0;
    return (x + b) >>> QUANT_BITS;
  endfunction

  function automatic logic signed [W-1:0] reduce(
    input logic signed [SW-1:0] x
  );
`ifdef DEMOD_SATURATE_EN
    if (x > SMAX) begin
      return SMAX[W-1:0];
    end else if (x < SMIN) begin
      return SMIN[W-1:0];
    end else begin
      return x[W-1:0];
    end
`else
    return x[W-1:0];
`endif
  endfunction

  p1_t p1_q, p1_d;
  p2_t p2_q, p2_d;
  p3_t p3_q, p3_d;

  logic signed [W-1:0]  rprev_q, rprev_d;
  logic signed [W-1:0]  iprev_q, iprev_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic stall;
  logic accept;
  logic wr;

  logic signed [PW-1:0] dq_rr, dq_ii, dq_ri, dq_ir;
  logic signed [SW-1:0] r_sum, i_sum;

  assign stall  = p3_q.v && (out_i_full || out_r_full);
  assign accept = reset && !stall && !inA_empty && !inB_empty;
  assign wr     = reset && p3_q.v && !out_i_full && !out_r_full;

  assign dq_rr = dq(p2_q.rr);
  assign dq_ii = dq(p2_q.ii);
  assign dq_ri = dq(p2_q.ri);
  assign dq_ir = dq(p2_q.ir);

  assign r_sum = {dq_rr[PW-1], dq_rr} + {dq_ii[PW-1], dq_ii};
  assign i_sum = {dq_ri[PW-1], dq_ri} - {dq_ir[PW-1], dq_ir};

  always_comb begin
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    if (!stall) begin
      p1_d.v  = accept;
      p1_d.re = inA_dout;
      p1_d.im = inB_dout;
      p1_d.rp = restart ? '0 : rprev_q;
      p1_d.ip = restart ? '0 : iprev_q;
      p2_d.v  = p1_q.v;
      p2_d.rr = mul(p1_q.rp, p1_q.re);
      p2_d.ii = mul(p1_q.ip, p1_q.im);
      p2_d.ri = mul(p1_q.rp, p1_q.im);
      p2_d.ir = mul(p1_q.ip, p1_q.re);
      p3_d.v  = p2_q.v;
      p3_d.r  = reduce(r_sum);
      p3_d.i  = reduce(i_sum);
    end
  end

  // An accepted sample always becomes the new history, even under restart.
  always_comb begin
    rprev_d = rprev_q;
    iprev_d = iprev_q;
    priority case (1'b1)
      accept: begin
        rprev_d = inA_dout;
        iprev_d = inB_dout;
      end
      restart: begin
        rprev_d = '0;
        iprev_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    priority case (1'b1)
      restart: cnt_d = '0;
      wr:      cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      rprev_q <= '0;
      iprev_q <= '0;
      cnt_q   <= '0;
    end else begin
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      rprev_q <= rprev_d;
      iprev_q <= iprev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inA_rd_en    = accept;
  assign inB_rd_en    = accept;
  assign out_i_wr_en  = wr;
  assign out_r_wr_en  = wr;
  assign out_i_din    = wr ? p3_q.i : '0;
  assign out_r_din    = wr ? p3_q.r : '0;
  assign sample_count = cnt_q;
  assign busy         = p1_q.v || p2_q.v || p3_q.v;

endmodule

// File: tb/tb_demod_conj_mult_pipe.sv
// Randomized bench for demod_conj_mult_pipe against a queue-based reference model.
// Honours DEMOD_SATURATE_EN the same way as the design.
module tb_demod_conj_mult_pipe;

  localparam int DW = 32;
  localparam int QB = 10;
  localparam int CW = 32;
  localparam longint DIV  = 64'sd1 << QB;
  localparam longint LMAX = 64'sd2147483647;
  localparam longint LMIN = -64'sd2147483648;

  logic          clock = 1'b0;
  logic          reset;
  logic          restart;
  logic          inA_rd_en;
  logic          inA_empty;
  logic [DW-1:0] inA_dout;
  logic          inB_rd_en;
  logic          inB_empty;
  logic [DW-1:0] inB_dout;
  logic          out_i_wr_en;
  logic          out_i_full;
  logic [DW-1:0] out_i_din;
  logic          out_r_wr_en;
  logic          out_r_full;
  logic [DW-1:0] out_r_din;
  logic [CW-1:0] sample_count;
  logic          busy;

  always #5 clock = ~clock;

  demod_conj_mult_pipe #(
    .DATA_WIDTH (DW),
    .QUANT_BITS (QB),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .restart     (restart),
    .inA_rd_en   (inA_rd_en),
    .inA_empty   (inA_empty),
    .inA_dout    (inA_dout),
    .inB_rd_en   (inB_rd_en),
    .inB_empty   (inB_empty),
    .inB_dout    (inB_dout),
    .out_i_wr_en (out_i_wr_en),
    .out_i_full  (out_i_full),
    .out_i_din   (out_i_din),
    .out_r_wr_en (out_r_wr_en),
    .out_r_full  (out_r_full),
    .out_r_din   (out_r_din),
    .sample_count(sample_count),
    .busy        (busy)
  );

  typedef struct {
    int r;
    int i;
    int age;
  } ent_t;

  ent_t        q[$];
  int          fa[$];
  int          fb[$];
  int          wr_r[$];
  int          wr_i[$];
  int          rprev = 0;
  int          iprev = 0;
  int unsigned cnt = 0;

  bit rst_v = 1'b0;
  bit rs_v  = 1'b0;
  bit fi_v  = 1'b0;
  bit fr_v  = 1'b0;
  bit e_rd, e_wr, e_stall, s_rst, s_rs;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic void ref_calc(input int rp, input int ip,
                                   input int re, input int im,
                                   output int r, output int i);
    longint a, b, c, d, rs, is;
    a  = (longint'(rp) * longint'(re)) / DIV;
    b  = (longint'(ip) * longint'(im)) / DIV;
    c  = (longint'(rp) * longint'(im)) / DIV;
    d  = (longint'(ip) * longint'(re)) / DIV;
    rs = a + b;
    is = c - d;
`ifdef DEMOD_SATURATE_EN
    if (rs > LMAX) rs = LMAX;
    if (rs < LMIN) rs = LMIN;
    if (is > LMAX) is = LMAX;
    if (is < LMIN) is = LMIN;
`endif
    r = int'(rs);
    i = int'(is);
  endfunction

  task automatic apply();
    reset      = rst_v;
    restart    = rs_v;
    out_i_full = fi_v;
    out_r_full = fr_v;
    inA_empty  = (fa.size() == 0);
    inB_empty  = (fb.size() == 0);
    inA_dout   = inA_empty ? '0 : fa[0];
    inB_dout   = inB_empty ? '0 : fb[0];
  endtask

  task automatic check();
    bit hr;
    int xr, xi;
    hr      = (q.size() > 0) && (q[0].age >= 3);
    e_stall = hr && (fi_v || fr_v);
    e_wr    = rst_v && hr && !fi_v && !fr_v;
    e_rd    = rst_v && !e_stall && (fa.size() > 0) && (fb.size() > 0);
    xr = 0;
    xi = 0;
    if (e_wr) begin
      xr = q[0].r;
      xi = q[0].i;
    end
    chk("inA_rd_en", inA_rd_en, e_rd);
    chk("inB_rd_en", inB_rd_en, e_rd);
    chk("out_i_wr_en", out_i_wr_en, e_wr);
    chk("out_r_wr_en", out_r_wr_en, e_wr);
    chk("out_i_din", $signed(out_i_din), xi);
    chk("out_r_din", $signed(out_r_din), xr);
    chk("busy", busy, q.size() > 0);
    chk("sample_count", sample_count, cnt);
    if (out_i_wr_en === 1'b1) begin
      wr_r.push_back($signed(out_r_din));
      wr_i.push_back($signed(out_i_din));
    end
    s_rst = rst_v;
    s_rs  = rs_v;
  endtask

  task automatic update();
    int re, im, rp, ip, r, i;
    ent_t e;
    if (!s_rst) begin
      q.delete();
      rprev = 0;
      iprev = 0;
      cnt   = 0;
    end else begin
      if (e_wr) begin
        void'(q.pop_front());
        cnt++;
      end
      if (s_rs) cnt = 0;
      if (!e_stall) begin
        foreach (q[k]) q[k].age++;
      end
      if (e_rd) begin
        re = fa.pop_front();
        im = fb.pop_front();
        rp = s_rs ? 0 : rprev;
        ip = s_rs ? 0 : iprev;
        ref_calc(rp, ip, re, im, r, i);
        e.r   = r;
        e.i   = i;
        e.age = 1;
        q.push_back(e);
        rprev = re;
        iprev = im;
      end else if (s_rs) begin
        rprev = 0;
        iprev = 0;
      end
    end
    rs_v = 1'b0;
  endtask

  task automatic step();
    apply();
    @(negedge clock);
    check();
    @(posedge clock);
    #1;
    update();
  endtask

  task automatic drain();
    int k;
    fi_v = 1'b0;
    fr_v = 1'b0;
    k = 0;
    while ((q.size() > 0 || (fa.size() > 0 && fb.size() > 0)) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) fail_now("drain_timeout");
  endtask

  task automatic push(input int re, input int im);
    fa.push_back(re);
    fb.push_back(im);
  endtask

  task automatic clear_log();
    wr_r.delete();
    wr_i.delete();
  endtask

  task automatic lit(input string name, input int idx,
                     input int er, input int ei);
    if (wr_r.size() > idx) begin
      chk({name, "_r"}, wr_r[idx], er);
      chk({name, "_i"}, wr_i[idx], ei);
    end else begin
      fail_now({name, "_missing"});
    end
  endtask

  task automatic pulse_restart();
    rs_v = 1'b1;
    step();
    clear_log();
  endtask

  function automatic int rnd_data();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom());
      1: v = $urandom_range(0, 6000) - 3000;
      2: v = $urandom_range(0, 1) ? int'(32'h8000_0000) : int'(32'h7fff_ffff);
      default: v = $urandom_range(0, 2097152) - 1048576;
    endcase
    return v;
  endfunction

  int mn;

  initial begin
    mn = int'(32'h8000_0000);

    rst_v = 1'b0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_wr", out_i_wr_en, 0);
    chk("reset_count", sample_count, 0);
    rst_v = 1'b1;

    clear_log();
    push(1024, 0);
    push(0, 1024);
    drain();
    lit("basic0", 0, 0, 0);
    lit("basic1", 1, 0, 1024);
    chk("basic_count", sample_count, 2);
    chk("basic_writes", wr_r.size(), 2);

    pulse_restart();
    push(-1500, 0);
    push(1, 0);
    drain();
    lit("trunc0", 0, 0, 0);
    lit("trunc1", 1, -1, 0);

    pulse_restart();
    for (int k = 0; k < 8; k++) push(k * 700 - 2500, 3000 - k * 411);
    repeat (4) step();
    fr_v = 1'b1;
    repeat (5) step();
    fr_v = 1'b0;
    drain();
    chk("bp_writes", wr_r.size(), 8);
    chk("bp_count", sample_count, 8);

    pulse_restart();
    push(1024, 0);
    step();
    push(0, 1024);
    rs_v = 1'b1;
    step();
    drain();
    lit("restart0", 0, 0, 0);
    lit("restart1", 1, 0, 0);
    chk("restart_count", sample_count, 2);

    pulse_restart();
    push(mn, 0);
    push(0, mn);
    drain();
`ifdef DEMOD_SATURATE_EN
    lit("ovf1", 1, 0, 2147483647);
`else
    lit("ovf1", 1, 0, 0);
`endif

    pulse_restart();
    push(100, 200);
    push(300, 400);
    push(500, 600);
    repeat (3) step();
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_wr", out_r_wr_en, 0);
    chk("midrst_count", sample_count, 0);
    clear_log();
    push(5000, 7000);
    drain();
    chk("midrst_writes", wr_r.size(), 1);
    lit("midrst0", 0, 0, 0);

    for (int c = 0; c < 1500; c++) begin
      if (fa.size() < 8 && $urandom_range(0, 3) != 0) fa.push_back(rnd_data());
      if (fb.size() < 8 && $urandom_range(0, 3) != 0) fb.push_back(rnd_data());
      fi_v  = ($urandom_range(0, 5) == 0);
      fr_v  = ($urandom_range(0, 5) == 0);
      rs_v  = ($urandom_range(0, 40) == 0);
      rst_v = ($urandom_range(0, 200) != 0);
      step();
    end
    rst_v = 1'b1;
    drain();
    step();
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
